ushift_reg_burst: RTL and testbench

//   Parametrised universal shift register: hold, shift right, shift left, parallel load, with

---
 rtl/ushift_pkg.sv | 8 +
 rtl/ushift_burst_ctrl.sv | 70 +++++++
 rtl/ushift_reg_burst.sv | 65 ++++++
 tb/tb_ushift_reg_burst.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ushift_pkg.sv
// ushift_pkg: shared mode codes and burst FSM state encoding for the universal shift register.
package ushift_pkg;
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;
    typedef enum logic {ST_IDLE, ST_RUN} state_e;
endpackage

// File: rtl/ushift_burst_ctrl.sv
// ushift_burst_ctrl: burst FSM, down-counter and busy/done; picks the op the datapath executes.
module ushift_burst_ctrl
    import ushift_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          sclr,
    input  logic [1:0]    mode,
    input  logic          rot,
    input  logic          start,
    input  logic [CW-1:0] burst_len,
    output logic [1:0]    op_o,
    output logic          rot_o,
    output logic          busy_o,
    output logic          done_o
);
    state_e        st_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    dir_q;
    logic          rot_q;
    logic          busy_q;
    logic          done_q;
    logic          go;

    assign go = start && (mode == MODE_SHR || mode == MODE_SHL);
    // The start edge itself never shifts; a running burst overrides mode and rot.
    assign op_o   = (st_q == ST_RUN) ? dir_q : (go ? MODE_HOLD : mode);
    assign rot_o  = (st_q == ST_RUN) ? rot_q : rot;
    assign busy_o = busy_q;
    assign done_o = done_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            dir_q  <= MODE_SHR;
            rot_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (sclr) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (en) begin
            done_q <= 1'b0;
            if (st_q == ST_RUN) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    st_q   <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (go) begin
                dir_q <= mode;
                rot_q <= rot;
                cnt_q <= burst_len;
                if (burst_len != '0) begin
                    st_q   <= ST_RUN;
                    busy_q <= 1'b1;
                end else begin
                    done_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/ushift_reg_burst.sv
// ushift_reg_burst: universal shift register (hold/shr/shl/load, optional rotate) with burst mode.
module ushift_reg_burst
    import ushift_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             sclr,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] d,
    input  logic             start,
    input  logic [CW-1:0]    burst_len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic             busy,
    output logic             done
);
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [1:0]       op;
    logic             rot_e;
    logic             b_r;
    logic             b_l;

    ushift_burst_ctrl #(.CW(CW)) u_ctrl (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .sclr      (sclr),
        .mode      (mode),
        .rot       (rot),
        .start     (start),
        .burst_len (burst_len),
        .op_o      (op),
        .rot_o     (rot_e),
        .busy_o    (busy),
        .done_o    (done)
    );

    assign b_r = rot_e ? q_q[0] : ser_in;
    assign b_l = rot_e ? q_q[WIDTH-1] : ser_in;

    always_comb begin
        q_d = op == MODE_SHR  ? {b_r, q_q[WIDTH-1:1]} :
              op == MODE_SHL  ? {q_q[WIDTH-2:0], b_l} :
              op == MODE_LOAD ? d : q_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)     q_q <= RESET_VAL;
        else if (sclr) q_q <= RESET_VAL;
        else if (en)   q_q <= q_d;
    end

    assign q         = q_q;
    assign ser_out_r = q_q[0];
    assign ser_out_l = q_q[WIDTH-1];
endmodule

// File: tb/tb_ushift_reg_burst.sv
// tb_ushift_reg_burst: directed scenarios plus randomized run against a behavioural model.
module tb_ushift_reg_burst;
    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       en = 1'b1;
    logic       sclr = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       rot = 1'b0;
    logic       ser_in = 1'b0;
    logic [7:0] d = 8'h00;
    logic       start = 1'b0;
    logic [3:0] burst_len = 4'd0;
    logic [7:0] q;
    logic       ser_out_r;
    logic       ser_out_l;
    logic       busy;
    logic       done;
    int         tests = 0;
    int         fails = 0;

    ushift_reg_burst #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .sclr      (sclr),
        .mode      (mode),
        .rot       (rot),
        .ser_in    (ser_in),
        .d         (d),
        .start     (start),
        .burst_len (burst_len),
        .q         (q),
        .ser_out_r (ser_out_r),
        .ser_out_l (ser_out_l),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        start = 1'b0;
        mode  = 2'b11;
        d     = v;
        tick();
        mode  = 2'b00;
    endtask

    task automatic test_reset();
        d = 8'hFF; mode = 2'b11; rstn = 1'b0;
        #1;
        tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_async q=%h busy=%b done=%b exp 00/0/0", q, busy, done); end
        tick(); tick();
        tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_held q=%h busy=%b done=%b exp 00/0/0", q, busy, done); end
        rstn = 1'b1; mode = 2'b00;
        tick();
    endtask

    task automatic test_shift();
        load(8'hA5);
        tests++; if (q !== 8'hA5) begin fails++; $display("FAIL load_a5 q=%h exp a5", q); end
        mode = 2'b01; rot = 1'b0; ser_in = 1'b1;
        tick();
        tests++; if (q !== 8'hD2 || ser_out_r !== 1'b0 || ser_out_l !== 1'b1) begin fails++; $display("FAIL shr1 q=%h sr=%b sl=%b exp d2/0/1", q, ser_out_r, ser_out_l); end
        tick();
        tests++; if (q !== 8'hE9 || ser_out_r !== 1'b1) begin fails++; $display("FAIL shr2 q=%h sr=%b exp e9/1", q, ser_out_r); end
        mode = 2'b00;
    endtask

    task automatic test_rotate();
        load(8'h81);
        mode = 2'b10; rot = 1'b1; ser_in = 1'b0;
        tick();
        tests++; if (q !== 8'h03) begin fails++; $display("FAIL rotl q=%h exp 03", q); end
        mode = 2'b01;
        tick(); tick();
        tests++; if (q !== 8'hC0) begin fails++; $display("FAIL rotr q=%h exp c0", q); end
        mode = 2'b00; rot = 1'b0;
    endtask

    task automatic test_burst();
        logic [7:0] exp_q [3] = '{8'h02, 8'h04, 8'h08};
        load(8'h01);
        start = 1'b1; mode = 2'b10; rot = 1'b0; ser_in = 1'b0; burst_len = 4'd3;
        tick();
        tests++; if (q !== 8'h01 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL burst_start q=%h busy=%b done=%b exp 01/1/0", q, busy, done); end
        start = 1'b0; mode = 2'b11; d = 8'hFF; rot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (q !== exp_q[i] || busy !== (i < 2) || done !== (i == 2)) begin fails++; $display("FAIL burst_step%0d q=%h busy=%b done=%b exp %h/%b/%b", i, q, busy, done, exp_q[i], i < 2, i == 2); end
        end
        mode = 2'b00; rot = 1'b0;
        tick();
        tests++; if (q !== 8'h08 || done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL burst_after q=%h busy=%b done=%b exp 08/0/0", q, busy, done); end
    endtask

    task automatic test_zero_len();
        start = 1'b1; mode = 2'b01; burst_len = 4'd0;
        tick();
        tests++; if (q !== 8'h08 || busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL zero_len q=%h busy=%b done=%b exp 08/0/1", q, busy, done); end
        start = 1'b0; mode = 2'b00; en = 1'b0;
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL done_held done=%b exp 1", done); end
        en = 1'b1;
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_clear done=%b exp 0", done); end
        start = 1'b1; mode = 2'b11; d = 8'h3C; burst_len = 4'd4;
        tick();
        tests++; if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL start_load q=%h busy=%b done=%b exp 3c/0/0", q, busy, done); end
        start = 1'b0; mode = 2'b00;
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL start_load2 busy=%b done=%b exp 0/0", busy, done); end
    endtask

    task automatic test_abort_pause();
        int seen_done;
        load(8'h01);
        start = 1'b1; mode = 2'b10; rot = 1'b0; ser_in = 1'b0; burst_len = 4'd5;
        tick();
        start = 1'b0;
        tick(); tick();
        tests++; if (q !== 8'h04 || busy !== 1'b1) begin fails++; $display("FAIL abort_pre q=%h busy=%b exp 04/1", q, busy); end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL abort q=%h busy=%b done=%b exp 00/0/0", q, busy, done); end
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (done) seen_done++; end
        tests++; if (seen_done != 0) begin fails++; $display("FAIL abort_nodone got %0d pulses exp 0", seen_done); end
        load(8'h01);
        start = 1'b1; mode = 2'b10; burst_len = 4'd5;
        tick();
        start = 1'b0;
        tick(); tick();
        en = 1'b0;
        tick(); tick();
        tests++; if (q !== 8'h04 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL pause q=%h busy=%b done=%b exp 04/1/0", q, busy, done); end
        en = 1'b1;
        tick(); tick();
        tests++; if (q !== 8'h10 || busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL pause_resume q=%h busy=%b done=%b exp 10/1/0", q, busy, done); end
        tick();
        tests++; if (q !== 8'h20 || busy !== 1'b0 || done !== 1'b1) begin fails++; $display("FAIL pause_end q=%h busy=%b done=%b exp 20/0/1", q, busy, done); end
        mode = 2'b00;
        tick();
    endtask

    function automatic logic [7:0] shift8(input logic [7:0] v, input logic [1:0] dir, input bit r, input bit si);
        bit b;
        b = r ? (dir == 2'b01 ? v[0] : v[7]) : si;
        return dir == 2'b01 ? ((v >> 1) | (8'(b) << 7)) : ((v << 1) | 8'(b));
    endfunction

    task automatic test_random();
        logic [7:0] mq = 8'h00;
        int         mleft = 0;
        logic [1:0] mdir = 2'b01;
        bit         mrot = 1'b0;
        bit         mdone = 1'b0;
        bit         ndone;
        sclr = 1'b1; start = 1'b0;
        tick();
        for (int i = 0; i < 600; i++) begin
            sclr      = ($urandom_range(0, 39) == 0);
            en        = ($urandom_range(0, 99) < 85);
            mode      = 2'($urandom);
            rot       = 1'($urandom);
            ser_in    = 1'($urandom);
            d         = 8'($urandom);
            start     = ($urandom_range(0, 4) == 0);
            burst_len = 4'($urandom);
            tick();
            if (sclr) begin
                mq = 8'h00; mleft = 0; mdone = 1'b0;
            end else if (en) begin
                ndone = 1'b0;
                if (mleft > 0) begin
                    mq = shift8(mq, mdir, mrot, ser_in);
                    mleft--;
                    ndone = (mleft == 0);
                end else if (start && (mode == 2'b01 || mode == 2'b10)) begin
                    mdir = mode; mrot = rot; mleft = burst_len;
                    ndone = (burst_len == 0);
                end else if (mode == 2'b11) begin
                    mq = d;
                end else if (mode != 2'b00) begin
                    mq = shift8(mq, mode, rot, ser_in);
                end
                mdone = ndone;
            end
            tests++; if (q !== mq || busy !== (mleft > 0) || done !== mdone) begin fails++; $display("FAIL rand%0d q=%h busy=%b done=%b exp %h/%b/%b", i, q, busy, done, mq, mleft > 0, mdone); end
            if (i % 97 == 50) begin
                rstn = 1'b0;
                #2;
                tests++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rand_rst q=%h busy=%b done=%b exp 00/0/0", q, busy, done); end
                rstn = 1'b1;
                mq = 8'h00; mleft = 0; mdone = 1'b0;
            end
        end
        sclr = 1'b0; en = 1'b1; start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_burst();
        test_zero_len();
        test_abort_pause();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
